tdc_pattern_readout_scheduler: RTL and testbench
================================================

// Module: tdc_pattern_readout_scheduler
// PURPOSE
//  Collects the 30-bit test-pattern words {pixelID[7:0], BCID[11:0], L1 counter[8:0], hit} from
//  NPIX pixel pattern generators. Snapshots them on each bunch-crossing strobe, keeping only hit words.
//  Drains the kept words one per handshake, in rotating priority, to a single valid/ready output.
//  Sits between the per-pixel pattern generators and the column readout buffer.
// PARAMETERS
//  NPIX   4   number of pixel generators served (2..16)
//  WORDW  30  pixel word width; bit 0 is the hit flag
//  CNTW   8   width of the saturating overflow counter
// PORTS
//  clk          in   1           40 MHz clock
//  reset        in   1           synchronous, active-low reset
//  dis          in   1           1 = block disabled: pending data flushed, output idle
//  bx_strobe    in   1           1-cycle pulse: sample pix_words this cycle
//  pix_words    in   NPIX*WORDW  packed words; pixel i at [i*WORDW +: WORDW]
//  dout         out  WORDW       output word (registered)
//  dout_valid   out  1           dout holds a valid word
//  dout_ready   in   1           downstream accepts dout when dout_valid is high
//  busy         out  1           1 whenever state != IDLE
//  overflow_cnt out  CNTW        snapshots dropped, saturating at all-ones
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   - state=IDLE; hold regs=0; pending mask=0; start pointer=0.
//   - dout=0; dout_valid=0; overflow_cnt=0.
//   - Applies mid-drain too: the in-flight word is lost with no partial output.
//  dis==1: same clearing as reset, except overflow_cnt is held. bx_strobe is ignored while dis==1.
//  States:
//   - IDLE: bx_strobe -> load hold[i]=pix_words[i] and pending[i]=pix_words[i][0].
//     Then start=(start+1)%NPIX. Go to LOAD if pending!=0; otherwise stay in IDLE (or go to TRAILER, see CONFIGURATION).
//   - LOAD: pick the first pending index scanning upward from start, wrapping modulo NPIX.
//     Register dout=hold[idx], set dout_valid=1, clear pending[idx]. Go to DRAIN.
//   - DRAIN: hold dout and dout_valid stable while dout_ready==0.
//     On dout_valid&dout_ready: if pending!=0, pick the next index as in LOAD, update dout in the same edge, keep valid=1.
//     Otherwise dout_valid=0 and go to IDLE (or TRAILER).
//  Latency:
//   - bx_strobe high in cycle n -> first dout_valid in cycle n+2.
//   - Back-to-back words every cycle while dout_ready==1. K hits drain in K cycles after the first.
//  Scan pointer: start advances once per accepted snapshot, including empty ones. It gives rotating fairness across snapshots.
//  Overflow: bx_strobe while state != IDLE -> snapshot dropped, overflow_cnt+=1 (saturating). This includes the cycle in which the last word is accepted.
//  Simultaneous dis and bx_strobe: dis wins, and overflow_cnt does not increment.
//  No word is ever duplicated or reordered within a snapshot. dout is X-free: it stays 0 until the first load.
// CONFIGURATION
//  `TDC_SCHED_TRAILER_EN defined:
//   - Every accepted snapshot, including empty ones, ends with a TRAILER state.
//   - TRAILER emits one word through the same handshake, then returns to IDLE.
//   - Word = {8'hFF, 12'(hit count of snapshot), 9'h1FF, 1'b0}. busy stays high until it is accepted.
//  Not defined: no TRAILER state; only hit words are emitted; empty snapshots produce no output.
// TESTING
//  1. NPIX=4; strobe with hits at pixels 1,3 (start=0 before); ready=1 -> strobe cycle n: hold 1 then 3 in n+2,n+3; valid low n+4.
//  2. Same hits, ready low for 5 cycles after first valid -> dout=word1 held stable; word3 follows one cycle after ready rises.
//  3. All 4 hit, second strobe 2 cycles after first -> second dropped, overflow_cnt=1; 4 words out; 255 drops -> saturates at 8'hFF.
//  4. Consecutive snapshots all-hit -> first output order 1,2,3,0; next snapshot 2,3,0,1 (rotating start).
//  5. reset low mid-drain after 2 of 4 words -> next cycle valid=0, dout=0, busy=0, overflow_cnt=0; next strobe works normally.
//  6. With TDC_SCHED_TRAILER_EN: empty strobe -> single word {8'hFF,12'd0,9'h1FF,1'b0}; 2 hits -> 2 words then count=2 trailer.

Source files
------------

// File: rtl/tdc_pattern_readout_scheduler.sv
// Snapshots NPIX pixel test-pattern words on bx_strobe and drains the hit words in rotating priority
// over one valid/ready port. Optional trailer word per snapshot: define TDC_SCHED_TRAILER_EN.
module tdc_pattern_readout_scheduler #(
  parameter int NPIX  = 4,
  parameter int WORDW = 30,
  parameter int CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dis,
  input  logic                    bx_strobe,
  input  logic [NPIX*WORDW-1:0]   pix_words,
  output logic [WORDW-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic [CNTW-1:0]         overflow_cnt
);

  localparam int IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, TRAILER} state_t;

  state_t                  state_q, state_d;
  logic [NPIX*WORDW-1:0]   hold_q, hold_d;
  logic [NPIX-1:0]         pending_q, pending_d;
  logic [IDXW-1:0]         start_q, start_d;
  logic [WORDW-1:0]        dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic [CNTW-1:0]         ovf_q, ovf_d;

  logic [IDXW-1:0]         idx;
  logic [NPIX-1:0]         strobe_hits;

  function automatic logic [NPIX-1:0] hit_bits(input logic [NPIX*WORDW-1:0] w);
    logic [NPIX-1:0] r;
    for (int i = 0; i < NPIX; i++) r[i] = w[i*WORDW];
    return r;
  endfunction

  // First set bit at or above s, wrapping; lowest rotation distance wins.
  function automatic logic [IDXW-1:0] pick(input logic [NPIX-1:0] p, input logic [IDXW-1:0] s);
    logic [IDXW-1:0] r;
    r = '0;
    for (int k = NPIX - 1; k >= 0; k--) begin
      int j;
      j = (int'(s) + k) % NPIX;
      if (p[j]) r = IDXW'(j);
    end
    return r;
  endfunction

  function automatic logic [IDXW-1:0] next_start(input logic [IDXW-1:0] s);
    return (int'(s) == NPIX - 1) ? '0 : s + 1'b1;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

`ifdef TDC_SCHED_TRAILER_EN
  function automatic logic [WORDW-1:0] trailer_word(input logic [NPIX-1:0] h);
    logic [11:0] c;
    c = '0;
    for (int i = 0; i < NPIX; i++) c = c + 12'(h[i]);
    return WORDW'({8'hFF, c, 9'h1FF, 1'b0});
  endfunction
`endif

  always_comb begin
    strobe_hits = hit_bits(pix_words);
    idx         = pick(pending_q, start_q);
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    pending_d    = pending_q;
    start_d      = start_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ovf_d        = ovf_q;

    case (state_q)
      IDLE: begin
        if (bx_strobe) begin
          hold_d    = pix_words;
          pending_d = strobe_hits;
          start_d   = next_start(start_q);
          if (|strobe_hits) begin
            state_d = LOAD;
          end else begin
`ifdef TDC_SCHED_TRAILER_EN
            dout_d       = trailer_word(strobe_hits);
            dout_valid_d = 1'b1;
            state_d      = TRAILER;
`else
            state_d      = IDLE;
`endif
          end
        end
      end
      LOAD: begin
        dout_d         = hold_q[int'(idx)*WORDW +: WORDW];
        dout_valid_d   = 1'b1;
        pending_d[idx] = 1'b0;
        state_d        = DRAIN;
      end
      DRAIN: begin
        if (dout_valid_q && dout_ready) begin
          if (|pending_q) begin
            dout_d         = hold_q[int'(idx)*WORDW +: WORDW];
            pending_d[idx] = 1'b0;
          end else begin
`ifdef TDC_SCHED_TRAILER_EN
            dout_d       = trailer_word(hit_bits(hold_q));
            state_d      = TRAILER;
`else
            dout_valid_d = 1'b0;
            state_d      = IDLE;
`endif
          end
        end
      end
      TRAILER: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe arriving while any snapshot is still in flight is dropped and counted.
    if (bx_strobe && state_q != IDLE) ovf_d = sat_inc(ovf_q);

    if (dis) begin
      state_d      = IDLE;
      hold_d       = '0;
      pending_d    = '0;
      start_d      = '0;
      dout_d       = '0;
      dout_valid_d = 1'b0;
      ovf_d        = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      pending_q    <= '0;
      start_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      start_q      <= start_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign busy         = (state_q != IDLE);
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_tdc_pattern_readout_scheduler.sv
// Scoreboard bench for tdc_pattern_readout_scheduler: snapshot-level model feeds an expected-word queue,
// a negedge monitor compares every presented word, valid, busy and overflow count.
module tb_tdc_pattern_readout_scheduler;

  localparam int NPIX  = 4;
  localparam int WORDW = 30;
  localparam int CNTW  = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  dis = 1'b0;
  logic                  bx_strobe = 1'b0;
  logic [NPIX*WORDW-1:0] pix_words = '0;
  logic [WORDW-1:0]      dout;
  logic                  dout_valid;
  logic                  dout_ready = 1'b0;
  logic                  busy;
  logic [CNTW-1:0]       overflow_cnt;

  tdc_pattern_readout_scheduler #(.NPIX(NPIX), .WORDW(WORDW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .dis(dis), .bx_strobe(bx_strobe), .pix_words(pix_words),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WORDW-1:0] exp_q[$];
  logic [CNTW-1:0]  ovf_exp = '0;
  int               start_m = 0;
  int               edge_n = 0;
  int               loaded_edge = -1;
  int               clear_edge = -1;
  bit               seen_load = 0;
  bit               fin_req = 0;
  bit               fin_done = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, req);
    end
  endtask

  // One clock of stimulus; the model is updated with what that edge must have done.
  task automatic cycle(input bit s, input logic [NPIX-1:0] mask, input bit rdy, input bit d, input bit rst_n);
    logic [NPIX*WORDW-1:0] w;
    bit accept, drop;
    int nhits;
    for (int i = 0; i < NPIX; i++)
      w[i*WORDW +: WORDW] = {8'(i), 12'($urandom), 9'($urandom), mask[i]};
    pix_words  = w;
    bx_strobe  = s;
    dout_ready = rdy;
    dis        = d;
    reset      = rst_n;
    accept = rst_n && !d && s && (exp_q.size() == 0);
    drop   = rst_n && !d && s && (exp_q.size() != 0);
    @(posedge clk);
    #1;
    if (!rst_n || d) begin
      exp_q.delete();
      start_m    = 0;
      clear_edge = edge_n;
      if (!rst_n) ovf_exp = '0;
    end else begin
      if (drop && ovf_exp != {CNTW{1'b1}}) ovf_exp = ovf_exp + 1'b1;
      if (accept) begin
        start_m = (start_m + 1) % NPIX;
        nhits   = 0;
        for (int k = 0; k < NPIX; k++) begin
          int p;
          p = (start_m + k) % NPIX;
          if (mask[p]) begin
            exp_q.push_back(w[p*WORDW +: WORDW]);
            nhits++;
          end
        end
`ifdef TDC_SCHED_TRAILER_EN
        exp_q.push_back({8'hFF, 12'(nhits), 9'h1FF, 1'b0});
`endif
        if (nhits > 0) loaded_edge = edge_n;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, '0, rdy, 0, 1);
  endtask

  always @(negedge clk) begin
    bit exp_v;
    if (clear_edge == edge_n) seen_load = 0;
    exp_v = (exp_q.size() != 0) && (loaded_edge != edge_n);
    chk("dout_valid", 32'(dout_valid), 32'(exp_v));
    chk("busy", 32'(busy), 32'(exp_q.size() != 0));
    chk("overflow_cnt", 32'(overflow_cnt), 32'(ovf_exp));
    if (dout_valid && exp_q.size() != 0) chk("dout", 32'(dout), 32'(exp_q[0]));
    else if (!dout_valid && !seen_load) chk("dout_cleared", 32'(dout), 32'd0);
    if (dout_valid) seen_load = 1;
    if (dout_valid && dout_ready && reset && !dis && exp_q.size() != 0) void'(exp_q.pop_front());
    if (fin_req && !fin_done) begin
      chk("all_drained", 32'(exp_q.size()), 32'd0);
      fin_done = 1;
    end
  end

  initial begin
    int guard;
    idle(0, 0);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    idle(2, 1);
    // hits at 1 and 3, ready high
    cycle(1, 4'b1010, 1, 0, 1);
    idle(5, 1);
    // same hits with a ready stall after the first word
    cycle(1, 4'b1010, 0, 0, 1);
    idle(7, 0);
    idle(4, 1);
    // all hit, second strobe two cycles later is dropped
    cycle(1, 4'b1111, 1, 0, 1);
    idle(1, 1);
    cycle(1, 4'b0110, 1, 0, 1);
    idle(6, 1);
    // consecutive all-hit snapshots: rotating start
    cycle(1, 4'b1111, 1, 0, 1);
    idle(5, 1);
    cycle(1, 4'b1111, 1, 0, 1);
    idle(5, 1);
    // reset in the middle of a drain
    cycle(1, 4'b1111, 1, 0, 1);
    idle(3, 1);
    cycle(0, '0, 1, 0, 0);
    idle(2, 1);
    cycle(1, 4'b0101, 1, 0, 1);
    idle(5, 1);
    // overflow saturation, then disable holds the counter
    cycle(1, 4'b1111, 0, 0, 1);
    for (int i = 0; i < 300; i++) cycle(1, 4'($urandom), 0, 0, 1);
    cycle(1, 4'b1111, 1, 1, 1);
    idle(3, 1);
    cycle(1, 4'b0000, 1, 0, 1);
    idle(2, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 3) == 0, 4'($urandom), ($urandom % 4) != 0,
            ($urandom % 60) == 0, ($urandom % 250) != 0);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      idle(1, 1);
      guard++;
    end
    idle(2, 1);
    fin_req = 1;
    guard = 0;
    while (!fin_done && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (!fin_done) begin
      $display("FAIL monitor_finish: got no response expected completion");
      $fatal(1, "monitor did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
